// File: rtl/note_pkg.sv
// Shared constants and event-kind type for the note_select block.
package note_pkg;

    localparam int NUM_KEYS = 25;
    localparam int ID_W     = 5;
    localparam logic [ID_W-1:0] NONE_ID = 5'd31;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_PRESS,
        EV_RELEASE
    } ev_kind_t;

endpackage

// File: rtl/note_select_key_event_pick.sv
// Picks the next pending key event: releases before presses, lowest key index first.
module key_event_pick
    import note_pkg::*;
#(
    parameter int N = 25
) (
    input  logic [N-1:0]    release_v,
    input  logic [N-1:0]    press_v,
    output ev_kind_t        kind,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        kind = EV_NONE;
        idx  = '0;
        // Scan downward so the lowest set index is the last one written.
        if (|release_v) begin
            kind = EV_RELEASE;
            for (int i = N - 1; i >= 0; i--)
                if (release_v[i]) idx = ID_W'(i);
        end else if (|press_v) begin
            kind = EV_PRESS;
            for (int i = N - 1; i >= 0; i--)
                if (press_v[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/note_select.sv
// Tracks the two most recent held notes and reports them to the wave stage, rate-limited by vsync frames.
// Define NOTE_SORT_EN to emit the pair in ascending id order instead of recency order.
module note_select
    import note_pkg::*;
#(
    parameter int              NUM_KEYS       = note_pkg::NUM_KEYS,
    parameter int              HOLDOFF_FRAMES = 2,
    parameter logic [ID_W-1:0] NONE_ID        = note_pkg::NONE_ID
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_down,
    input  logic                vsync,
    output logic [ID_W-1:0]     freq_id1,
    output logic [ID_W-1:0]     freq_id2,
    output logic                new_f_in,
    output logic                pending
);

    logic [1:0]          rst_sync;
    logic                rst_int_n;
    logic [2:0]          vs_q;
    logic                vsync_fall;
    logic [NUM_KEYS-1:0] key_q, press_v, release_v;
    logic [NUM_KEYS-1:0] ev_mask, press_clr, release_clr;
    logic [ID_W-1:0]     s1, s2, s1_nxt, s2_nxt;
    logic                dirty, slot_chg, emit;
    logic [3:0]          holdoff;
    ev_kind_t            ev_kind;
    logic [ID_W-1:0]     ev_idx;

    // Reset asserts immediately, releases two clocks after reset_n rises.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    assign rst_int_n = rst_sync[1];

    assign vsync_fall = vs_q[2] & ~vs_q[1];

    key_event_pick #(.N(NUM_KEYS)) u_pick (
        .release_v (release_v),
        .press_v   (press_v),
        .kind      (ev_kind),
        .idx       (ev_idx)
    );

    always_comb begin
        ev_mask = '0;
        if (ev_kind != EV_NONE) ev_mask[ev_idx] = 1'b1;
        press_clr   = (ev_kind == EV_PRESS)   ? ev_mask : '0;
        release_clr = (ev_kind == EV_RELEASE) ? ev_mask : '0;
    end

    always_comb begin
        s1_nxt   = s1;
        s2_nxt   = s2;
        slot_chg = 1'b0;
        case (ev_kind)
            EV_RELEASE: begin
                if (s1 == ev_idx) begin
                    s1_nxt   = s2;
                    s2_nxt   = NONE_ID;
                    slot_chg = 1'b1;
                end else if (s2 == ev_idx) begin
                    s2_nxt   = NONE_ID;
                    slot_chg = 1'b1;
                end
            end
            EV_PRESS: begin
                if (s1 != ev_idx) begin
                    s2_nxt   = s1;
                    s1_nxt   = ev_idx;
                    slot_chg = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Only report once the whole batch of edges has been folded into the slots.
    assign emit = dirty && (holdoff == 4'd0) && !(|release_v) && !(|press_v);

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vs_q      <= '0;
            key_q     <= '0;
            press_v   <= '0;
            release_v <= '0;
            s1        <= NONE_ID;
            s2        <= NONE_ID;
            dirty     <= 1'b0;
            holdoff   <= '0;
            new_f_in  <= 1'b0;
            freq_id1  <= NONE_ID;
            freq_id2  <= NONE_ID;
        end else begin
            vs_q      <= {vs_q[1:0], vsync};
            key_q     <= key_down;
            press_v   <= (press_v   | (key_down & ~key_q)) & ~press_clr;
            release_v <= (release_v | (~key_down & key_q)) & ~release_clr;
            s1        <= s1_nxt;
            s2        <= s2_nxt;
            new_f_in  <= emit;
            if (emit) begin
                dirty   <= 1'b0;
                holdoff <= 4'(HOLDOFF_FRAMES);
`ifdef NOTE_SORT_EN
                freq_id1 <= (s1 <= s2) ? s1 : s2;
                freq_id2 <= (s1 <= s2) ? s2 : s1;
`else
                freq_id1 <= s1;
                freq_id2 <= s2;
`endif
            end else begin
                if (slot_chg) dirty <= 1'b1;
                if (vsync_fall && holdoff != 4'd0) holdoff <= holdoff - 4'd1;
            end
        end
    end

    assign pending = dirty;

endmodule

// File: tb/tb_note_select.sv
// Self-checking bench for note_select: directed table, multi-cycle sequences, and a random run against a list-based model.
module tb_note_select;

    localparam int NK   = 25;
    localparam int HF   = 2;
    localparam int NONE = 31;
`ifdef NOTE_SORT_EN
    localparam bit SORT = 1'b1;
`else
    localparam bit SORT = 1'b0;
`endif

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic [NK-1:0] key_down = '0;
    logic          vsync = 1'b0;
    logic [4:0]    freq_id1, freq_id2;
    logic          new_f_in, pending;

    note_select #(.NUM_KEYS(NK), .HOLDOFF_FRAMES(HF)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .key_down (key_down),
        .vsync    (vsync),
        .freq_id1 (freq_id1),
        .freq_id2 (freq_id2),
        .new_f_in (new_f_in),
        .pending  (pending)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int last1, last2;
    bit auto_vs = 1'b0;
    int vcnt = 0;

    // Reference model: recency list of held notes plus pending event sets.
    bit m_pp[NK], m_pr[NK], m_prev[NK];
    int m_slot[$];
    bit m_dirty, m_nf;
    int m_hold, m_f1 = NONE, m_f2 = NONE;
    bit mv1, mv2, mv3;
    int rcnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_pp[i]) begin m_pp[i] = 0; m_pr[i] = 0; m_prev[i] = 0; end
        m_slot.delete();
        m_dirty = 0; m_nf = 0; m_hold = 0; m_f1 = NONE; m_f2 = NONE;
        mv1 = 0; mv2 = 0; mv3 = 0;
    endtask

    task automatic model_edge(input logic [NK-1:0] kd, input logic v, input logic rn);
        bit emit, fall, rel, chg, anyp;
        int ev, t;
        if (!rn) begin model_clear(); rcnt = 0; return; end
        if (rcnt < 2) begin rcnt++; return; end
        anyp = 0;
        foreach (m_pp[i]) if (m_pp[i] || m_pr[i]) anyp = 1;
        emit = m_dirty && m_hold == 0 && !anyp;
        fall = mv3 && !mv2;
        ev = -1; rel = 0;
        for (int i = 0; i < NK; i++) if (ev < 0 && m_pr[i]) begin ev = i; rel = 1; end
        for (int i = 0; i < NK; i++) if (ev < 0 && m_pp[i]) ev = i;
        m_nf = emit;
        if (emit) begin
            m_f1 = (m_slot.size() > 0) ? m_slot[0] : NONE;
            m_f2 = (m_slot.size() > 1) ? m_slot[1] : NONE;
            if (SORT && m_f1 > m_f2) begin t = m_f1; m_f1 = m_f2; m_f2 = t; end
            m_hold = HF; m_dirty = 0;
        end else if (fall && m_hold > 0) m_hold--;
        chg = 0;
        if (ev >= 0 && rel) begin
            for (int j = 0; j < m_slot.size(); j++)
                if (!chg && m_slot[j] == ev) begin m_slot.delete(j); chg = 1; end
        end else if (ev >= 0) begin
            if (!(m_slot.size() > 0 && m_slot[0] == ev)) begin
                m_slot.push_front(ev);
                if (m_slot.size() > 2) void'(m_slot.pop_back());
                chg = 1;
            end
        end
        if (chg) m_dirty = 1;
        for (int i = 0; i < NK; i++) begin
            m_pp[i] |= kd[i] && !m_prev[i];
            m_pr[i] |= !kd[i] && m_prev[i];
            m_prev[i] = kd[i];
        end
        if (ev >= 0) begin if (rel) m_pr[ev] = 0; else m_pp[ev] = 0; end
        mv3 = mv2; mv2 = mv1; mv1 = v;
    endtask

    task automatic step();
        if (auto_vs) begin vcnt++; vsync = vcnt[2]; end
        @(posedge clock);
        model_edge(key_down, vsync, reset_n);
        #1;
        if (new_f_in) begin pulses++; last1 = freq_id1; last2 = freq_id2; end
        chk("model new_f_in", new_f_in, m_nf);
        chk("model freq_id1", freq_id1, m_f1);
        chk("model freq_id2", freq_id2, m_f2);
        chk("model pending", pending, m_dirty);
    endtask

    task automatic wait_pulse(input int maxc, input string nm, output int cyc);
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            step();
            if (new_f_in) begin cyc = k; break; end
        end
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL %s timeout: no new_f_in within %0d cycles", nm, maxc);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; key_down = '0; vsync = 1'b0; auto_vs = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();
    endtask

    typedef struct {
        logic [NK-1:0] keys;
        int            lat;
        int            e1;
        int            e2;
    } vec_t;

    vec_t tbl[6];
    int   sq_key[5], sq_dn[5], sq_e1[5], sq_e2[5];

    initial begin
        int cyc, bad31;
        logic [NK-1:0] one;
        one = NK'(1);
        tbl[0] = '{one << 7,                 2, 7,                 NONE};
        tbl[1] = '{(one << 4) | (one << 20), 3, SORT ? 4 : 20,     SORT ? 20 : 4};
        tbl[2] = '{one | (one << 24),        3, SORT ? 0 : 24,     SORT ? 24 : 0};
        tbl[3] = '{(one << 3) | (one << 9) | (one << 15), 4, SORT ? 9 : 15, SORT ? 15 : 9};
        tbl[4] = '{one << 24,                2, 24,                NONE};
        tbl[5] = '{(one << 1) | (one << 2),  3, SORT ? 1 : 2,      SORT ? 2 : 1};
        sq_key = '{3, 9, 15, 15, 9};
        sq_dn  = '{1, 1, 1, 0, 0};
        sq_e1  = SORT ? '{3, 3, 9, 9, NONE} : '{3, 9, 15, 9, NONE};
        sq_e2  = SORT ? '{NONE, 9, 15, NONE, NONE} : '{NONE, 3, 9, NONE, NONE};

        model_clear();
        #2 reset_n = 1'b0;
        do_reset();
        chk("reset freq_id1", freq_id1, NONE);
        chk("reset freq_id2", freq_id2, NONE);
        chk("reset new_f_in", new_f_in, 0);
        chk("reset pending", pending, 0);

        // Table: fresh state, apply a key pattern, check latency, pair and a single strobe.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            pulses = 0;
            key_down = tbl[i].keys;
            step();
            wait_pulse(40, "table", cyc);
            chk("table latency", cyc, tbl[i].lat);
            chk("table freq_id1", freq_id1, tbl[i].e1);
            chk("table freq_id2", freq_id2, tbl[i].e2);
            repeat (10) step();
            chk("table pulse count", pulses, 1);
        end

        // Holdoff: a second change waits for two vsync falls after the previous strobe.
        do_reset();
        key_down[7] = 1'b1;
        wait_pulse(20, "holdoff first", cyc);
        chk("holdoff first id1", freq_id1, 7);
        repeat (5) step();
        pulses = 0;
        key_down[12] = 1'b1;
        repeat (20) step();
        chk("holdoff no pulse before vsync", pulses, 0);
        chk("holdoff pending", pending, 1);
        vsync = 1'b1; repeat (4) step(); vsync = 1'b0;
        repeat (10) step();
        chk("holdoff no pulse after one fall", pulses, 0);
        chk("holdoff still pending", pending, 1);
        vsync = 1'b1; repeat (4) step(); vsync = 1'b0;
        wait_pulse(20, "holdoff second", cyc);
        chk("holdoff id1", freq_id1, SORT ? 7 : 12);
        chk("holdoff id2", freq_id2, SORT ? 12 : 7);

        // Press / release sequence with free-running vsync.
        do_reset();
        auto_vs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_down[sq_key[i]] = sq_dn[i][0];
            wait_pulse(80, "sequence", cyc);
            chk("sequence id1", freq_id1, sq_e1[i]);
            chk("sequence id2", freq_id2, sq_e2[i]);
        end

        // Reset while a change is pending: immediate clear, held keys come back as fresh presses.
        do_reset();
        key_down[7] = 1'b1;
        wait_pulse(20, "rstpend first", cyc);
        key_down[12] = 1'b1;
        repeat (5) step();
        chk("rstpend pending before", pending, 1);
        reset_n = 1'b0;
        #1;
        chk("rstpend async id1", freq_id1, NONE);
        chk("rstpend async id2", freq_id2, NONE);
        chk("rstpend async strobe", new_f_in, 0);
        chk("rstpend async pending", pending, 0);
        repeat (2) step();
        reset_n = 1'b1;
        wait_pulse(40, "rstpend refresh", cyc);
        chk("rstpend id1", freq_id1, SORT ? 7 : 12);
        chk("rstpend id2", freq_id2, SORT ? 12 : 7);

        // Quick release and re-press of the note in s1: one strobe, never an empty pair.
        do_reset();
        auto_vs = 1'b1;
        key_down[5] = 1'b1;
        wait_pulse(20, "repress first", cyc);
        repeat (40) step();
        auto_vs = 1'b0; vsync = 1'b0;
        repeat (5) step();
        pulses = 0; bad31 = 0;
        key_down[5] = 1'b0;
        step();
        key_down[5] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (new_f_in && freq_id1 == 5'(NONE)) bad31++;
        end
        chk("repress pulse count", pulses, 1);
        chk("repress no empty pulse", bad31, 0);
        chk("repress id1", last1, 5);
        chk("repress id2", last2, NONE);

        // Random key activity and vsync, checked every cycle against the model.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                int k;
                k = $urandom_range(0, NK - 1);
                key_down[k] = ~key_down[k];
            end
            if ($urandom_range(0, 29) == 0) begin
                int k;
                k = $urandom_range(0, NK - 1);
                key_down[k] = ~key_down[k];
            end
            if ($urandom_range(0, 6) == 0) vsync = ~vsync;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/note_select.md
Name: note_select

Overview:
- Sits directly upstream of the physics/wave stage and converts held note keys into its frequency-id interface.
- Tracks the two most recently pressed, still-held notes and drives freq_id1/freq_id2 (31 = no note) plus a one-clock new_f_in strobe.
- Rate-limits updates to a minimum number of frames so the downstream waveform swap and offset rescale can finish between changes.

Parameters:
- NUM_KEYS, 25, number of note keys; key index equals frequency id (0 lowest).
- HOLDOFF_FRAMES, 2, minimum vsync frames between two new_f_in pulses; range 0..15.
- NONE_ID, 31, id emitted for an empty slot.

Ports:
- clock  input  1  65 MHz system clock.
- reset_n  input  1  asynchronous, active-low reset.
- key_down  input  NUM_KEYS  debounced, clock-synchronous key levels; 1 = held.
- vsync  input  1  frame sync, asynchronous to key activity; 2-flop synchronised internally.
- freq_id1  output  5  most recent held note, or NONE_ID.
- freq_id2  output  5  second most recent held note, or NONE_ID.
- new_f_in  output  1  one-clock strobe; freq_id1/2 are valid in that cycle and held until the next strobe.
- pending  output  1  high while an unreported slot change is waiting on holdoff.

Behaviour:
- Reset (async assert, sync deassert): freq_id1 = freq_id2 = NONE_ID, new_f_in = 0, pending = 0, key_q = 0, press/release vectors cleared, holdoff counter = 0, working slots s1 = s2 = NONE_ID.
- Because key_q resets to 0, keys still held at reset release are treated as fresh presses.
- Edge capture, every clock:
  - key_q <= key_down.
  - press_v |= key_down & ~key_q.
  - release_v |= ~key_down & key_q.
  - Bits are cleared only when their event is processed; a new edge on an already-set bit is absorbed.
- Event processing, one event per clock:
  - Release events take priority over presses.
  - Within a class, the lowest key index goes first.
  - The processed bit is cleared in the same cycle; new edges on other bits are still ORed in.
- Release k:
  - If s1 == k: s1 <= s2, s2 <= NONE_ID.
  - Else if s2 == k: s2 <= NONE_ID.
  - Otherwise no slot change.
  - Any slot change sets dirty.
- Press k:
  - If s1 == k, no change.
  - Else s2 <= s1, s1 <= k, and dirty is set.
- Same key released and re-pressed before processing: the release is handled first, then the press, so the key ends up in s1.
- Emission:
  - Condition: dirty, holdoff == 0, and release_v == 0 and press_v == 0 (batch settled).
  - Next edge: new_f_in = 1, freq_id1 <= s1, freq_id2 <= s2, dirty <= 0, holdoff <= HOLDOFF_FRAMES.
  - new_f_in is never high on two consecutive clocks.
- Holdoff: decrements once per synchronised vsync falling edge while nonzero, and saturates at 0.
- pending = dirty.
- Latency for an isolated press with holdoff 0: key_down sampled high at edge E0; press_v set at E0; processed at E1; new_f_in high from E2 to E3.
- A net-zero batch (press then release of a note not already in a slot) still sets dirty and emits. Downstream tolerates a repeated id pair.

Optional Feature:
- Macro NOTE_SORT_EN.
- Defined: at emission, the pair is ordered so freq_id1 <= freq_id2 numerically (NONE_ID sorts last). Working slots s1/s2 keep recency order.
- Undefined: emitted in recency order as above.

Decomposition:
- Shared package note_pkg:
  - NONE_ID, NUM_KEYS, id width (5).
  - Event-kind typedef (EV_NONE, EV_PRESS, EV_RELEASE).
- One sub-module, key_event_pick: combinational lowest-index priority encoder over release_v/press_v, returning kind and index.
- vsync synchroniser and edge detect stay inline.

Test Plan:
- Reset with key_down = 0 → freq_id1 = freq_id2 = 31, new_f_in = 0. Then raise key 7 → single new_f_in pulse, freq_id1 = 7, freq_id2 = 31, 2 clocks after first sample.
- HOLDOFF_FRAMES = 2: hold 7, then press 12 mid-frame → pending = 1 and no pulse until the 2nd vsync fall after the first pulse; then pulse with (12, 7).
- Hold 3, 9, 15 in order, then release 15 → emitted (9, 3)... stays (9, 3)? No: slots become s1 = 9, s2 = 31 → pulse with (9, 31). Release 9 → (31, 31).
- Keys 4 and 20 rise in the same cycle → processed 4 then 20, one pulse with (20, 4). With NOTE_SORT_EN → (4, 20).
- Assert reset_n low during pending with a key held → outputs immediately 31/31, new_f_in = 0. After release, the held key produces a fresh pulse.
- Key 5 held in s1: release and re-press 5 within 1 cycle, holdoff 0 → pulse with freq_id1 = 5 and no intermediate pulse with 31.
